// File: rtl/imu_frame_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imu_frame_sync: camera trigger pulses phase-locked to IMU sample edges   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module imu_frame_sync #(
  parameter int NUM_CH          = 2,
  parameter int CNT_W           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int PULSE_CYCLES    = 500000,
  parameter int TIMEOUT_CYCLES  = 1000000,
  parameter int FALLBACK_CYCLES = 250000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    imu_int,
  input  logic                    enable,
  input  logic [CNT_W-1:0]        samples_per_frame,
  input  logic [NUM_CH*CNT_W-1:0] phase,
  input  logic [NUM_CH-1:0]       ch_enable,
  output logic [CNT_W-1:0]        sample_count,
  output logic [NUM_CH-1:0]       trigger_frame,
  output logic                    imu_lost,
  output logic [NUM_CH-1:0]       overrun
);

  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FALLBACK_CYCLES + 1);
  localparam logic [PW-1:0]    PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [WW-1:0]    WD_LAST    = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0]    FB_LAST    = FW'(FALLBACK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_LOW  = 2'b01,
    ST_HIGH = 2'b10
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  state_t                 state_q, state_d;
  logic                   evt_fsm_d, evt_fsm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      state_q   <= ST_LOW;
      evt_fsm_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], imu_int};
      state_q   <= state_d;
      evt_fsm_q <= evt_fsm_d;
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d   = ST_LOW;
    evt_fsm_d = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (sync_s) begin
          state_d   = ST_HIGH;
          evt_fsm_d = 1'b1;
        end
      end
      ST_HIGH: state_d = sync_s ? ST_HIGH : ST_LOW;
      default: state_d = ST_LOW;
    endcase
  end

  // A real IMU edge always wins: it clears the watchdog and restarts the fallback tick.
  logic [WW-1:0] wd_q;
  logic [FW-1:0] fb_q;
  logic          lost_q;
  logic          fb_tick;
  logic          evt;

  assign fb_tick = lost_q && (fb_q == FB_LAST);
  assign evt     = enable && (evt_fsm_q || fb_tick);

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q   <= '0;
      fb_q   <= '0;
      lost_q <= 1'b0;
    end else begin
      if (evt_fsm_q)            wd_q <= '0;
      else if (wd_q != WD_LAST) wd_q <= wd_q + WW'(1);

      if (evt_fsm_q)            lost_q <= 1'b0;
      else if (wd_q == WD_LAST) lost_q <= 1'b1;

      if (!lost_q || evt_fsm_q || fb_tick) fb_q <= '0;
      else                                 fb_q <= fb_q + FW'(1);
    end
  end

  logic [CNT_W-1:0]  n_frame;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [NUM_CH-1:0] fire_d, fire_q;

  assign n_frame = (samples_per_frame == '0) ? CNT_ONE : samples_per_frame;

  always_comb begin
    cnt_d = cnt_q;
    if (evt) cnt_d = (cnt_q >= n_frame - CNT_ONE) ? '0 : cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      fire_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      fire_q <= fire_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] ph;
    logic             trig_d, trig_q;
    logic             ovr_d, ovr_q;
    logic [PW-1:0]    pcnt_d, pcnt_q;

    assign ph        = phase[i*CNT_W +: CNT_W];
    assign fire_d[i] = evt && ch_enable[i] && (ph == cnt_q) && (ph < n_frame);

    // A fire landing on a live pulse only flags overrun; the countdown keeps running.
    always_comb begin
      trig_d = trig_q;
      pcnt_d = pcnt_q;
      ovr_d  = ovr_q;
      if (trig_q) begin
        if (pcnt_q == '0) trig_d = 1'b0;
        else              pcnt_d = pcnt_q - PW'(1);
        if (fire_q[i])    ovr_d  = 1'b1;
      end else if (fire_q[i]) begin
        trig_d = 1'b1;
        pcnt_d = PULSE_LAST;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        trig_q <= 1'b0;
        pcnt_q <= '0;
        ovr_q  <= 1'b0;
      end else begin
        trig_q <= trig_d;
        pcnt_q <= pcnt_d;
        ovr_q  <= ovr_d;
      end
    end

    assign trigger_frame[i] = trig_q;
    assign overrun[i]       = ovr_q;
  end : g_ch

  assign sample_count = cnt_q;
  assign imu_lost     = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_imu_frame_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_imu_frame_sync: directed bench for imu_frame_sync                     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_imu_frame_sync;

  localparam int P = 6;
  localparam int T = 60;
  localparam int F = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        imu_int;
  logic        enable;
  logic [7:0]  spf;
  logic [15:0] phase;
  logic [1:0]  ch_en;
  logic [7:0]  sample_count;
  logic [1:0]  trigger_frame;
  logic        imu_lost;
  logic [1:0]  overrun;

  int total = 0;
  int bad   = 0;

  imu_frame_sync #(
    .NUM_CH(2), .CNT_W(8), .SYNC_STAGES(2),
    .PULSE_CYCLES(P), .TIMEOUT_CYCLES(T), .FALLBACK_CYCLES(F)
  ) dut (
    .clk(clk), .rst(rst), .imu_int(imu_int), .enable(enable),
    .samples_per_frame(spf), .phase(phase), .ch_enable(ch_en),
    .sample_count(sample_count), .trigger_frame(trigger_frame),
    .imu_lost(imu_lost), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    imu_int = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse(input int hi, input int lo);
    imu_int = 1'b1;
    for (int j = 0; j < hi; j++) tick();
    imu_int = 1'b0;
    for (int j = 0; j < lo; j++) tick();
  endtask

  task automatic test_reset();
    enable = 1'b1; spf = 8'd4; phase = {8'd2, 8'd0}; ch_en = 2'b11;
    do_reset();
    total++; if (sample_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", sample_count); end
    total++; if (trigger_frame !== 2'b00) begin bad++; $display("FAIL reset_trig got=%b want=00", trigger_frame); end
    total++; if (imu_lost !== 1'b0) begin bad++; $display("FAIL reset_lost got=%b want=0", imu_lost); end
    total++; if (overrun !== 2'b00) begin bad++; $display("FAIL reset_ovr got=%b want=00", overrun); end
    for (int j = 0; j < 10; j++) tick();
    total++; if (trigger_frame !== 2'b00) begin bad++; $display("FAIL startup_trig got=%b want=00", trigger_frame); end
  endtask

  task automatic test_frame();
    logic [1:0] exp_t;
    enable = 1'b1; spf = 8'd4; phase = {8'd2, 8'd0}; ch_en = 2'b11;
    do_reset();
    for (int n = 0; n < 12; n++) begin
      exp_t = (n % 4 == 0) ? 2'b01 : ((n % 4 == 2) ? 2'b10 : 2'b00);
      imu_int = 1'b1;
      for (int j = 0; j < 10; j++) begin
        if (j == 3) imu_int = 1'b0;
        tick();
        if (j == 0) begin
          total++; if (trigger_frame !== 2'b00) begin bad++; $display("FAIL frame_idle n=%0d got=%b want=00", n, trigger_frame); end
        end
        if (j == 3) begin
          total++; if (sample_count !== 8'((n + 1) % 4)) begin bad++; $display("FAIL frame_count n=%0d got=%0d want=%0d", n, sample_count, (n + 1) % 4); end
        end
        if (j >= 4) begin
          total++; if (trigger_frame !== exp_t) begin bad++; $display("FAIL frame_trig n=%0d j=%0d got=%b want=%b", n, j, trigger_frame, exp_t); end
        end
      end
    end
  endtask

  task automatic test_glitch();
    enable = 1'b1; spf = 8'd8; phase = {8'd2, 8'd0}; ch_en = 2'b00;
    do_reset();
    imu_int = 1'b1;
    for (int j = 0; j < 40; j++) begin
      if (j == 30) imu_int = 1'b0;
      tick();
      if (j == 3) begin
        total++; if (sample_count !== 8'd1) begin bad++; $display("FAIL hold_first got=%0d want=1", sample_count); end
      end
    end
    total++; if (sample_count !== 8'd1) begin bad++; $display("FAIL hold_once got=%0d want=1", sample_count); end
    // high 5, low 1, high 5, low 5
    for (int j = 0; j < 16; j++) begin
      imu_int = (j < 5) || (j >= 6 && j < 11);
      tick();
      if (j == 4) begin
        total++; if (sample_count !== 8'd2) begin bad++; $display("FAIL glitch_pre got=%0d want=2", sample_count); end
      end
    end
    total++; if (sample_count !== 8'd3) begin bad++; $display("FAIL glitch_edge got=%0d want=3", sample_count); end
  endtask

  task automatic test_watchdog();
    enable = 1'b1; spf = 8'd8; phase = {8'd2, 8'd0}; ch_en = 2'b00;
    do_reset();
    for (int j = 0; j < 115; j++) begin
      imu_int = (j < 3) || (j >= 106 && j < 109);
      tick();
      case (j)
        62: begin total++; if (imu_lost !== 1'b0) begin bad++; $display("FAIL wd_early got=%b want=0", imu_lost); end end
        63: begin total++; if (imu_lost !== 1'b1) begin bad++; $display("FAIL wd_timeout got=%b want=1", imu_lost); end end
        82: begin total++; if (sample_count !== 8'd1) begin bad++; $display("FAIL fb_pre1 got=%0d want=1", sample_count); end end
        83: begin total++; if (sample_count !== 8'd2) begin bad++; $display("FAIL fb_tick1 got=%0d want=2", sample_count); end end
        102: begin total++; if (sample_count !== 8'd2) begin bad++; $display("FAIL fb_pre2 got=%0d want=2", sample_count); end end
        103: begin total++; if (sample_count !== 8'd3) begin bad++; $display("FAIL fb_tick2 got=%0d want=3", sample_count); end end
        108: begin total++; if (imu_lost !== 1'b1) begin bad++; $display("FAIL resume_pre got=%b want=1", imu_lost); end end
        109: begin
          total++; if (imu_lost !== 1'b0) begin bad++; $display("FAIL resume_clear got=%b want=0", imu_lost); end
          total++; if (sample_count !== 8'd4) begin bad++; $display("FAIL resume_count got=%0d want=4", sample_count); end
        end
        default: ;
      endcase
    end
    total++; if (sample_count !== 8'd4) begin bad++; $display("FAIL resume_hold got=%0d want=4", sample_count); end
  endtask

  task automatic test_limits();
    enable = 1'b1; spf = 8'd8; phase = {8'd0, 8'd0}; ch_en = 2'b00;
    do_reset();
    for (int n = 0; n < 6; n++) pulse(3, 7);
    total++; if (sample_count !== 8'd6) begin bad++; $display("FAIL spf8_count got=%0d want=6", sample_count); end
    spf = 8'd3;
    pulse(3, 7);
    total++; if (sample_count !== 8'd0) begin bad++; $display("FAIL shrink_wrap got=%0d want=0", sample_count); end
    spf = 8'd0; ch_en = 2'b01;
    for (int n = 0; n < 3; n++) begin
      imu_int = 1'b1;
      for (int j = 0; j < 10; j++) begin
        if (j == 3) imu_int = 1'b0;
        tick();
        if (j == 3) begin
          total++; if (sample_count !== 8'd0) begin bad++; $display("FAIL spf0_count n=%0d got=%0d want=0", n, sample_count); end
        end
        if (j == 4) begin
          total++; if (trigger_frame !== 2'b01) begin bad++; $display("FAIL spf0_fire n=%0d got=%b want=01", n, trigger_frame); end
        end
      end
    end
    total++; if (overrun !== 2'b00) begin bad++; $display("FAIL spf0_ovr got=%b want=00", overrun); end
  endtask

  task automatic test_overrun();
    enable = 1'b1; spf = 8'd1; phase = {8'd0, 8'd0}; ch_en = 2'b01;
    do_reset();
    for (int j = 0; j < 14; j++) begin
      imu_int = (j < 12) && ((j % 4) < 2);
      tick();
      case (j)
        4: begin total++; if (trigger_frame !== 2'b01) begin bad++; $display("FAIL ovr_start got=%b want=01", trigger_frame); end end
        7: begin total++; if (overrun !== 2'b00) begin bad++; $display("FAIL ovr_pre got=%b want=00", overrun); end end
        8: begin total++; if (overrun !== 2'b01) begin bad++; $display("FAIL ovr_set got=%b want=01", overrun); end end
        9: begin total++; if (trigger_frame !== 2'b01) begin bad++; $display("FAIL ovr_last got=%b want=01", trigger_frame); end end
        10: begin total++; if (trigger_frame !== 2'b00) begin bad++; $display("FAIL ovr_noext got=%b want=00", trigger_frame); end end
        12: begin total++; if (trigger_frame !== 2'b01) begin bad++; $display("FAIL ovr_refire got=%b want=01", trigger_frame); end end
        default: ;
      endcase
    end
    total++; if (overrun !== 2'b01) begin bad++; $display("FAIL ovr_sticky got=%b want=01", overrun); end
  endtask

  task automatic test_reset_enable();
    enable = 1'b1; spf = 8'd1; phase = {8'd0, 8'd0}; ch_en = 2'b01;
    do_reset();
    for (int j = 0; j < 9; j++) begin
      imu_int = (j < 6) && ((j % 4) < 2);
      tick();
      if (j == 8) begin
        total++; if (trigger_frame !== 2'b01) begin bad++; $display("FAIL mid_trig got=%b want=01", trigger_frame); end
        total++; if (overrun !== 2'b01) begin bad++; $display("FAIL mid_ovr got=%b want=01", overrun); end
      end
    end
    rst = 1'b1;
    tick();
    total++; if (trigger_frame !== 2'b00) begin bad++; $display("FAIL rst_trig got=%b want=00", trigger_frame); end
    total++; if (overrun !== 2'b00) begin bad++; $display("FAIL rst_ovr got=%b want=00", overrun); end
    total++; if (sample_count !== 8'd0 || imu_lost !== 1'b0) begin bad++; $display("FAIL rst_state got=%0d/%b want=0/0", sample_count, imu_lost); end
    rst = 1'b0;
    for (int j = 0; j < 6; j++) tick();
    total++; if (trigger_frame !== 2'b00) begin bad++; $display("FAIL rst_spurious got=%b want=00", trigger_frame); end
    spf = 8'd4;
    for (int j = 0; j < 20; j++) begin
      if (j == 5) enable = 1'b0;
      imu_int = (j < 3) || (j >= 5 && j < 8) || (j >= 14 && j < 17);
      tick();
      if (j == 4) begin
        total++; if (trigger_frame !== 2'b01) begin bad++; $display("FAIL en_fire got=%b want=01", trigger_frame); end
      end
      if (j == 9) begin
        total++; if (trigger_frame !== 2'b01) begin bad++; $display("FAIL en_keep got=%b want=01", trigger_frame); end
      end
      if (j == 10) begin
        total++; if (trigger_frame !== 2'b00) begin bad++; $display("FAIL en_end got=%b want=00", trigger_frame); end
      end
    end
    total++; if (sample_count !== 8'd1) begin bad++; $display("FAIL en_hold got=%0d want=1", sample_count); end
    total++; if (trigger_frame !== 2'b00) begin bad++; $display("FAIL en_notrig got=%b want=00", trigger_frame); end
    enable = 1'b1;
  endtask

  initial begin
    rst = 1'b1; imu_int = 1'b0; enable = 1'b1;
    spf = 8'd4; phase = 16'd0; ch_en = 2'b00;
    test_reset();
    test_frame();
    test_glitch();
    test_watchdog();
    test_limits();
    test_overrun();
    test_reset_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
